hex_entry_loader: RTL and testbench
===================================

# hex_entry_loader

Front-panel input path for the lab board: the write side of the hex display path. The seven-segment displays read processor state out; this block lets the user write 16-bit words into instruction memory from the board. It debounces one push key and shifts the 4-bit switch value into an entry word, one nibble per press. After four nibbles it writes the word to the memory write port through a req/ack handshake. The address then auto-increments.

## Interface
Parameters:
- DB_COUNT, 50000: consecutive stable cycles needed to accept a key level change (1 ms at 50 MHz). Benches use 4.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge
- Reset  in  1  asynchronous, active-high reset
- key_n  in  1  raw push key, active-low, asynchronous to Clk, may bounce
- sw_mode  in  1  0 = nibble entry, 1 = address set; sampled on an accepted press
- nibble  in  4  switch value shifted in on press (sw_mode=0)
- addr_in  in  8  address loaded on press (sw_mode=1)
- mem_req  out  1  write request
- mem_addr  out  8  write address, equals addr_ptr
- mem_data  out  16  write data
- mem_ack  in  1  single-cycle write acknowledge from memory
- entry_word  out  16  partial word, for display
- nib_count  out  2  nibbles entered in the current word
- addr_ptr  out  8  next write address
- busy  out  1  high in WRITE

## Operation
Debounce:
- Two-flop synchronizer on key_n, then a stable-level register with counter.
- The counter increments each cycle the synchronized value differs from the stable level. It clears when they match.
- When the counter reaches DB_COUNT-1 while still differing, the stable level takes the new value and the counter clears.
- press_evt is a one-cycle pulse on each stable 1→0 transition. Release produces no event.

FSM, states ENTRY and WRITE. Reset state is ENTRY.

In ENTRY, on press_evt:
- sw_mode=1: addr_ptr ← addr_in; entry_word ← 0; nib_count ← 0.
- sw_mode=0, nib_count<3: entry_word ← {entry_word[11:0], nibble}; nib_count increments.
- sw_mode=0, nib_count=3: mem_data ← {entry_word[11:0], nibble}; mem_req ← 1; state ← WRITE. nib_count stays 3.

In WRITE:
- mem_req, mem_addr and mem_data stay constant until mem_ack.
- On the mem_ack cycle: mem_req ← 0; addr_ptr ← addr_ptr+1 (modulo 256, so 0xFF wraps to 0x00); entry_word ← 0; nib_count ← 0; state ← ENTRY.
- press_evt in WRITE is dropped, not queued. The debouncer keeps running.

mem_ack while in ENTRY is ignored.

Reset values: mem_req=0, mem_addr=0, mem_data=0, entry_word=0, nib_count=0, addr_ptr=0, busy=0. Stable level=1 and counter=0.

Reset asserted mid-WRITE returns every output to its reset value immediately. The pending write is abandoned.

## Timing
- With no bounce, a raw key_n falling edge updates the stable level at clock edge DB_COUNT+2 after the change.
- press_evt is high for the following cycle. The FSM acts on edge DB_COUNT+3.
- The fourth press sets mem_req on the same edge that the FSM acts on it.
- Minimum write occupancy is 1 cycle, with mem_ack in the first cycle of req.
- mem_req falls, and addr_ptr updates, on the edge that samples mem_ack=1.
- busy is the registered state decode (WRITE). It rises with mem_req.
- Outputs are registered; there are no combinational paths from input to output.

## Structure
- Shared package hex_entry_pkg holds the state enum (ENTRY, WRITE) and the DB_COUNT default constant.
- One sub-module, key_debounce (synchronizer, counter, stable level, press_evt), parameterized by DB_COUNT.
- The FSM and datapath live in hex_entry_loader.

## Test plan
(all with DB_COUNT=4)
- Reset: assert Reset mid-simulation → all outputs 0 asynchronously, before the next Clk edge.
- Bounce: a key_n low pulse of 3 cycles, then high → no press_evt and no change in nib_count.
- Word entry: presses with nibble 1, 2, 3, 4 and sw_mode=0 → after the fourth, mem_req=1, mem_addr=0x00, mem_data=0x1234. Then mem_ack after 3 cycles → outputs held stable, mem_req drops, addr_ptr=0x01, nib_count=0.
- Wrap-around: a sw_mode=1 press with addr_in=0xFF, then word 0xABCD, acked → write seen at 0xFF, addr_ptr=0x00.
- Press during WRITE: a press with nibble 7 while mem_req=1 → ignored. After ack, entry_word=0 and nib_count=0.
- Reset mid-WRITE: Reset while mem_req=1 → mem_req=0 and addr_ptr=0. A later mem_ack has no effect.

Source files
------------

// File: rtl/hex_entry_loader_pkg.sv
// hex_entry_pkg
// Shared definitions for the front-panel hex entry loader:
//   - state_e          : FSM state encoding (ENTRY, WRITE)
//   - DB_COUNT_DEFAULT : debounce length in cycles (1 ms at 50 MHz)
//   - shift_nibble()   : appends a switch nibble to the low end of a word
package hex_entry_pkg;

  typedef enum logic [0:0] {
    ENTRY = 1'b0,
    WRITE = 1'b1
  } state_e;

  localparam int unsigned DB_COUNT_DEFAULT = 50000;

  // Older nibbles move toward the MSB so the word reads left to right on the
  // display in the order it was typed.
  function automatic logic [15:0] shift_nibble(input logic [15:0] w, input logic [3:0] n);
    return {w[11:0], n};
  endfunction

endpackage

// File: rtl/hex_entry_loader_if.sv
// hex_entry_loader_if
// Memory write port between the loader (master) and instruction memory (slave).
//   req  : write request, held until ack
//   addr : write address
//   data : write data
//   ack  : single-cycle acknowledge from memory
interface hex_entry_loader_if;
  logic        req;
  logic [7:0]  addr;
  logic [15:0] data;
  logic        ack;

  modport master (output req, output addr, output data, input ack);
  modport slave  (input req, input addr, input data, output ack);
endinterface

// File: rtl/hex_entry_loader_key_debounce.sv
// key_debounce
// Synchronizes and debounces an active-low push key and emits a one-cycle
// pulse on each accepted press (stable 1 -> 0). Release gives no pulse.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_key_n      : raw key, active-low, asynchronous, may bounce
//   o_press_evt  : registered one-cycle press pulse
// DB_COUNT must be at least 2.
module key_debounce
  import hex_entry_pkg::*;
#(
  parameter int unsigned DB_COUNT = DB_COUNT_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_key_n,
  output logic o_press_evt
);

  localparam int unsigned CW = $clog2(DB_COUNT);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_stable <= 1'b1;
      r_cnt    <= '0;
      r_press  <= 1'b0;
    end else begin
      r_sync1 <= i_key_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DB_COUNT - 1)) begin
        // Level has differed long enough: accept it. A new level of 0 means
        // the stable level just went 1 -> 0, i.e. a press.
        r_stable <= r_sync2;
        r_cnt    <= '0;
        r_press  <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_press_evt = r_press;

endmodule

// File: rtl/hex_entry_loader.sv
// hex_entry_loader
// Front-panel word entry: each debounced key press either loads the write
// address (i_sw_mode=1) or shifts in one switch nibble (i_sw_mode=0). The
// fourth nibble issues a memory write via req/ack; the address then advances.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_key_n      : raw push key, active-low
//   i_sw_mode    : 0 = nibble entry, 1 = address set
//   i_nibble     : switch nibble shifted in on press
//   i_addr_in    : address loaded on an address-set press
//   mem          : memory write port (master side)
//   o_entry_word : partial word for display
//   o_nib_count  : nibbles entered in the current word
//   o_addr_ptr   : next write address
//   o_busy       : high while a write is outstanding
module hex_entry_loader
  import hex_entry_pkg::*;
#(
  parameter int unsigned DB_COUNT = DB_COUNT_DEFAULT
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_key_n,
  input  logic                       i_sw_mode,
  input  logic [3:0]                 i_nibble,
  input  logic [7:0]                 i_addr_in,
  hex_entry_loader_if.master         mem,
  output logic [15:0]                o_entry_word,
  output logic [1:0]                 o_nib_count,
  output logic [7:0]                 o_addr_ptr,
  output logic                       o_busy
);

  localparam logic [0:0] S_ENTRY = ENTRY;
  localparam logic [0:0] S_WRITE = WRITE;

  logic        w_press_evt;
  logic [0:0]  r_state;
  logic        r_mem_req;
  logic [15:0] r_mem_data;
  logic [15:0] r_entry_word;
  logic [1:0]  r_nib_count;
  logic [7:0]  r_addr_ptr;

  key_debounce #(
    .DB_COUNT (DB_COUNT)
  ) u_key_debounce (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_key_n     (i_key_n),
    .o_press_evt (w_press_evt)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_ENTRY;
      r_mem_req    <= 1'b0;
      r_mem_data   <= '0;
      r_entry_word <= '0;
      r_nib_count  <= '0;
      r_addr_ptr   <= '0;
    end else begin
      case (r_state)
        S_ENTRY: begin
          if (w_press_evt) begin
            if (i_sw_mode) begin
              r_addr_ptr   <= i_addr_in;
              r_entry_word <= '0;
              r_nib_count  <= '0;
            end else if (r_nib_count != 2'd3) begin
              r_entry_word <= shift_nibble(r_entry_word, i_nibble);
              r_nib_count  <= r_nib_count + 2'd1;
            end else begin
              // Fourth nibble goes straight to the write data; the display
              // word keeps the first three until the write completes.
              r_mem_data <= shift_nibble(r_entry_word, i_nibble);
              r_mem_req  <= 1'b1;
              r_state    <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          // Presses here are dropped; only the acknowledge moves us on.
          if (mem.ack) begin
            r_mem_req    <= 1'b0;
            r_addr_ptr   <= r_addr_ptr + 8'd1;
            r_entry_word <= '0;
            r_nib_count  <= '0;
            r_state      <= S_ENTRY;
          end
        end
        default: r_state <= S_ENTRY;
      endcase
    end
  end

  assign mem.req      = r_mem_req;
  assign mem.addr     = r_addr_ptr;
  assign mem.data     = r_mem_data;
  assign o_entry_word = r_entry_word;
  assign o_nib_count  = r_nib_count;
  assign o_addr_ptr   = r_addr_ptr;
  assign o_busy       = (r_state == S_WRITE);

endmodule

// File: tb/tb_hex_entry_loader.sv
// tb_hex_entry_loader
// Table-driven bench for hex_entry_loader with DB_COUNT=4, plus hand-written
// sequences for press-to-request latency, reset and reset mid-write.
module tb_hex_entry_loader;

  localparam int K_PRESS  = 0;
  localparam int K_ACK    = 1;
  localparam int K_BOUNCE = 2;
  localparam int NVEC     = 17;

  typedef struct {
    int          kind;
    logic        sw;
    logic [3:0]  nib;
    logic [7:0]  ain;
    logic        req;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [15:0] entry;
    logic [1:0]  cnt;
    logic        busy;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        key_n;
  logic        sw_mode;
  logic [3:0]  nibble;
  logic [7:0]  addr_in;
  logic [15:0] entry_word;
  logic [1:0]  nib_count;
  logic [7:0]  addr_ptr;
  logic        busy;

  int checks;
  int errors;
  vec_t tbl [NVEC];

  hex_entry_loader_if mem_bus ();

  hex_entry_loader #(
    .DB_COUNT (4)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_key_n      (key_n),
    .i_sw_mode    (sw_mode),
    .i_nibble     (nibble),
    .i_addr_in    (addr_in),
    .mem          (mem_bus.master),
    .o_entry_word (entry_word),
    .o_nib_count  (nib_count),
    .o_addr_ptr   (addr_ptr),
    .o_busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input int idx, input vec_t v);
    check({tag, "_req"},   idx, 16'(mem_bus.req),  16'(v.req));
    check({tag, "_addr"},  idx, 16'(mem_bus.addr), 16'(v.addr));
    check({tag, "_data"},  idx, mem_bus.data,      v.data);
    check({tag, "_entry"}, idx, entry_word,        v.entry);
    check({tag, "_cnt"},   idx, 16'(nib_count),    16'(v.cnt));
    check({tag, "_busy"},  idx, 16'(busy),         16'(v.busy));
    check({tag, "_ptr"},   idx, 16'(addr_ptr),     16'(v.addr));
  endtask

  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_press(input logic sw, input logic [3:0] nib, input logic [7:0] ain);
    sw_mode = sw;
    nibble  = nib;
    addr_in = ain;
    key_n   = 1'b0;
    repeat (10) @(posedge clk);
    #1 key_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic do_bounce(input logic [3:0] nib);
    sw_mode = 1'b0;
    nibble  = nib;
    key_n   = 1'b0;
    repeat (3) @(posedge clk);
    #1 key_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
  endtask

  // Hold for three cycles checking the write port is frozen, then ack once.
  task automatic do_ack(input int idx, input vec_t prev);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("hold_req",  idx, 16'(mem_bus.req),  16'(prev.req));
      check("hold_addr", idx, 16'(mem_bus.addr), 16'(prev.addr));
      check("hold_data", idx, mem_bus.data,      prev.data);
    end
    mem_bus.ack = 1'b1;
    @(posedge clk);
    #1 mem_bus.ack = 1'b0;
  endtask

  initial begin
    vec_t z;
    vec_t w;
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    key_n       = 1'b1;
    sw_mode     = 1'b0;
    nibble      = 4'h0;
    addr_in     = 8'h00;
    mem_bus.ack = 1'b0;

    //            kind      sw    nib   ain    req   addr   data      entry     cnt   busy
    tbl[0]  = '{K_PRESS,  1'b0, 4'h1, 8'h00, 1'b0, 8'h00, 16'h0000, 16'h0001, 2'd1, 1'b0};
    tbl[1]  = '{K_PRESS,  1'b0, 4'h2, 8'h00, 1'b0, 8'h00, 16'h0000, 16'h0012, 2'd2, 1'b0};
    tbl[2]  = '{K_PRESS,  1'b0, 4'h3, 8'h00, 1'b0, 8'h00, 16'h0000, 16'h0123, 2'd3, 1'b0};
    tbl[3]  = '{K_PRESS,  1'b0, 4'h4, 8'h00, 1'b1, 8'h00, 16'h1234, 16'h0123, 2'd3, 1'b1};
    tbl[4]  = '{K_ACK,    1'b0, 4'h0, 8'h00, 1'b0, 8'h01, 16'h1234, 16'h0000, 2'd0, 1'b0};
    tbl[5]  = '{K_ACK,    1'b0, 4'h0, 8'h00, 1'b0, 8'h01, 16'h1234, 16'h0000, 2'd0, 1'b0};
    tbl[6]  = '{K_PRESS,  1'b1, 4'h0, 8'hFF, 1'b0, 8'hFF, 16'h1234, 16'h0000, 2'd0, 1'b0};
    tbl[7]  = '{K_PRESS,  1'b0, 4'hA, 8'h00, 1'b0, 8'hFF, 16'h1234, 16'h000A, 2'd1, 1'b0};
    tbl[8]  = '{K_PRESS,  1'b0, 4'hB, 8'h00, 1'b0, 8'hFF, 16'h1234, 16'h00AB, 2'd2, 1'b0};
    tbl[9]  = '{K_PRESS,  1'b0, 4'hC, 8'h00, 1'b0, 8'hFF, 16'h1234, 16'h0ABC, 2'd3, 1'b0};
    tbl[10] = '{K_PRESS,  1'b0, 4'hD, 8'h00, 1'b1, 8'hFF, 16'hABCD, 16'h0ABC, 2'd3, 1'b1};
    tbl[11] = '{K_PRESS,  1'b0, 4'h7, 8'h00, 1'b1, 8'hFF, 16'hABCD, 16'h0ABC, 2'd3, 1'b1};
    tbl[12] = '{K_ACK,    1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 16'hABCD, 16'h0000, 2'd0, 1'b0};
    tbl[13] = '{K_PRESS,  1'b0, 4'h5, 8'h00, 1'b0, 8'h00, 16'hABCD, 16'h0005, 2'd1, 1'b0};
    tbl[14] = '{K_BOUNCE, 1'b0, 4'h9, 8'h00, 1'b0, 8'h00, 16'hABCD, 16'h0005, 2'd1, 1'b0};
    tbl[15] = '{K_PRESS,  1'b0, 4'h6, 8'h00, 1'b0, 8'h00, 16'hABCD, 16'h0056, 2'd2, 1'b0};
    tbl[16] = '{K_PRESS,  1'b0, 4'h7, 8'h00, 1'b0, 8'h00, 16'hABCD, 16'h0567, 2'd3, 1'b0};

    z = '{K_PRESS, 1'b0, 4'h0, 8'h00, 1'b0, 8'h00, 16'h0000, 16'h0000, 2'd0, 1'b0};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_all("reset", -1, z);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < NVEC; i++) begin
      case (tbl[i].kind)
        K_PRESS:  do_press(tbl[i].sw, tbl[i].nib, tbl[i].ain);
        K_ACK:    do_ack(i, tbl[i-1]);
        default:  do_bounce(tbl[i].nib);
      endcase
      check_all("vec", i, tbl[i]);
      $display("step %0d kind %0d req=%b addr=%h data=%h entry=%h cnt=%0d busy=%b",
               i, tbl[i].kind, mem_bus.req, mem_bus.addr, mem_bus.data, entry_word, nib_count, busy);
    end

    // Fourth press: request must rise on edge DB_COUNT+3 = 7 after key_n falls.
    sw_mode = 1'b0;
    nibble  = 4'h8;
    key_n   = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("lat_req_early", 6, 16'(mem_bus.req), 16'h0000);
    @(posedge clk);
    #1;
    check("lat_req",  7, 16'(mem_bus.req),  16'h0001);
    check("lat_busy", 7, 16'(busy),         16'h0001);
    check("lat_data", 7, mem_bus.data,      16'h5678);
    check("lat_addr", 7, 16'(mem_bus.addr), 16'h0000);
    $display("step latency req=%b data=%h addr=%h", mem_bus.req, mem_bus.data, mem_bus.addr);
    key_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;

    // Reset mid-write: outputs clear before the next rising edge.
    w = '{K_PRESS, 1'b0, 4'h0, 8'h00, 1'b1, 8'h00, 16'h5678, 16'h0567, 2'd3, 1'b1};
    check_all("prewrite", 0, w);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_all("midrst", 0, z);
    $display("step midreset req=%b addr=%h busy=%b", mem_bus.req, mem_bus.addr, busy);
    @(posedge clk);
    #1 rst = 1'b0;
    mem_bus.ack = 1'b1;
    @(posedge clk);
    #1 mem_bus.ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all("postrst_ack", 0, z);
    $display("step late_ack req=%b addr=%h busy=%b", mem_bus.req, mem_bus.addr, busy);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
